// File: rtl/uart_tx_if.sv
// Host-side bus of the UART transmitter.
//   tx_start     : write strobe (accepted when tx_start && tx_ready)
//   tx_din       : data word, sampled on the accept cycle
//   tx_ready     : holding register empty
//   tx_busy      : frame in progress
//   tx_done_tick : one-clk pulse when a frame's stop period completes
//   tx           : serial line, idle high
// master = host side, slave = transmitter side.
interface uart_tx_if #(
  parameter int DBIT = 8
);
  logic            tx_start;
  logic [DBIT-1:0] tx_din;
  logic            tx_ready;
  logic            tx_busy;
  logic            tx_done_tick;
  logic            tx;

  modport master (
    output tx_start, tx_din,
    input  tx_ready, tx_busy, tx_done_tick, tx
  );

  modport slave (
    input  tx_start, tx_din,
    output tx_ready, tx_busy, tx_done_tick, tx
  );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter driven by a shared 16x-oversampling tick (s_tick).
// Frame: start bit (0), DBIT data bits LSB first, optional parity bit,
// stop period of SB_TICK ticks (1). A one-word holding register lets the
// host queue the next word so frames go out back to back with no gap.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high
//   s_tick : one-clk pulse at 16x baud rate
//   bus    : host bus (tx_start/tx_din in; tx_ready/tx_busy/tx_done_tick/tx out)
module uart_transmitter #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     s_tick,
  uart_tx_if.slave bus
);
  localparam int NW = $clog2(DBIT);
  // Tick counter must reach both 15 (bit cells) and SB_TICK-1 (stop period).
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] hold_q, hold_d;
  logic            hv_q, hv_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            done;
  logic            accept;

  assign accept = bus.tx_start && !hv_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    hold_d  = hold_q;
    hv_d    = hv_q;
    par_d   = par_q;
    done    = 1'b0;
    tx_d    = 1'b1;

    if (accept) begin
      hold_d = bus.tx_din;
      hv_d   = 1'b1;
    end

    case (state_q)
      IDLE: begin
        s_d = '0;
        if (hv_q) begin
          b_d     = hold_q;
          hv_d    = 1'b0;
          state_d = START;
        end else if (accept) begin
          // Idle with nothing queued: bypass the holding register.
          b_d     = bus.tx_din;
          hold_d  = hold_q;
          hv_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == SW'(15)) begin
            s_d     = '0;
            n_d     = '0;
            par_d   = 1'b0;
            state_d = DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == SW'(15)) begin
            s_d   = '0;
            par_d = par_q ^ b_q[0];
            b_d   = b_q >> 1;
            if (n_q == NW'(DBIT - 1)) begin
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_q == SW'(15)) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            done = 1'b1;
            s_d  = '0;
            // Queued word goes straight into the next start bit.
            if (hv_q) begin
              b_d     = hold_q;
              hv_d    = 1'b0;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = '0;
      end
    endcase

    // Line value follows the next state so tx is a clean flop output.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      PARITY:  tx_d = par_d ^ PARITY_ODD[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      hold_q  <= '0;
      hv_q    <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      hold_q  <= hold_d;
      hv_q    <= hv_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.tx           = tx_q;
  assign bus.tx_ready     = !hv_q;
  assign bus.tx_busy      = (state_q != IDLE);
  assign bus.tx_done_tick = done;
endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter. Four instances share stimulus:
//   cfg0 defaults, cfg1 even parity, cfg2 odd parity, cfg3 SB_TICK=32.
// Each instance has a frame-level reference model: a frame is a list of
// 16-tick bit cells (start, data LSB first, optional parity) followed by the
// stop period, walked one s_tick at a time, with a one-word host queue.
module tb_uart_transmitter;
  logic       clk = 1'b0;
  logic       reset, s_tick, tx_start;
  logic [7:0] tx_din;
  bit         tick_rand;
  int         n_chk, n_fail;

  logic [3:0] tx_a, busy_a, ready_a, done_a;
  logic [3:0] m_tx_a, m_busy_a, m_ready_a, m_done_a;
  int         k_a [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam bit PE  = (g == 1 || g == 2);
    localparam bit PO  = (g == 2);
    localparam int SB  = (g == 3) ? 32 : 16;
    localparam int TOT = 16 * (9 + int'(PE)) + SB;

    uart_tx_if #(.DBIT(8)) bus_i ();
    assign bus_i.tx_start = tx_start;
    assign bus_i.tx_din   = tx_din;

    uart_transmitter #(.DBIT(8), .SB_TICK(SB), .PARITY_EN(int'(PE)),
                       .PARITY_ODD(int'(PO))) dut (
      .clk(clk), .reset(reset), .s_tick(s_tick), .bus(bus_i)
    );

    assign tx_a[g]    = bus_i.tx;
    assign busy_a[g]  = bus_i.tx_busy;
    assign ready_a[g] = bus_i.tx_ready;
    assign done_a[g]  = bus_i.tx_done_tick;

    // Reference model
    logic       act, hv;
    int         k;
    logic [7:0] cur, hw;

    function automatic logic line_val(int kk, logic [7:0] w);
      int b;
      b = kk / 16;
      if (b == 0) return 1'b0;
      if (b <= 8) return w[b-1];
      if (PE && b == 9) return (^w) ^ PO;
      return 1'b1;
    endfunction

    always @(posedge clk) begin
      if (reset) begin
        act <= 1'b0; hv <= 1'b0; k <= 0; cur <= '0; hw <= '0;
      end else if (!act) begin
        if (hv) begin
          cur <= hw; hv <= 1'b0; act <= 1'b1; k <= 0;
        end else if (tx_start) begin
          cur <= tx_din; act <= 1'b1; k <= 0;
        end
      end else begin
        if (tx_start && !hv) begin
          hw <= tx_din; hv <= 1'b1;
        end
        if (s_tick) begin
          if (k == TOT - 1) begin
            k <= 0;
            if (hv) begin
              cur <= hw; hv <= 1'b0;
            end else begin
              act <= 1'b0;
            end
          end else begin
            k <= k + 1;
          end
        end
      end
    end

    assign m_tx_a[g]    = act ? line_val(k, cur) : 1'b1;
    assign m_busy_a[g]  = act;
    assign m_ready_a[g] = !hv;
    assign m_done_a[g]  = act && s_tick && (k == TOT - 1);
    assign k_a[g]       = k;
  end

  // s_tick: every 4th clk, or random density when tick_rand is set.
  initial begin
    int c;
    c = 0;
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      c++;
      s_tick = tick_rand ? ($urandom_range(0, 2) == 0) : (c % 4 == 0);
    end
  end

  task automatic test_reset();
    reset = 1'b1; tx_start = 1'b0; tx_din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({tx_a, busy_a, ready_a, done_a} !== 16'hF0F0) begin
      n_fail++;
      $display("FAIL reset_state: tx/busy/ready/done got %h required F0F0",
               {tx_a, busy_a, ready_a, done_a});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_single_frame();
    int t, dn;
    int tq[$];
    int iv[6];
    logic last;
    iv = '{64, 64, 64, 128, 64, 64};
    @(posedge clk);
    #1;
    tx_start = 1'b1; tx_din = 8'hA5;
    @(negedge clk);
    n_chk++;
    if (tx_a !== 4'hF) begin
      n_fail++; $display("FAIL single_pre: tx got %h required F", tx_a);
    end
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    @(negedge clk);
    n_chk++;
    if (tx_a !== 4'h0) begin
      n_fail++; $display("FAIL single_fall: tx got %h required 0", tx_a);
    end
    last = 1'b0; t = 0; dn = 0;
    while (m_busy_a != 4'h0 && t < 2000) begin
      @(negedge clk);
      t++;
      n_chk++;
      if ({tx_a, busy_a, ready_a, done_a} !== {m_tx_a, m_busy_a, m_ready_a, m_done_a}) begin
        n_fail++;
        $display("FAIL single_cycle t=%0t: got %h required %h", $time,
                 {tx_a, busy_a, ready_a, done_a}, {m_tx_a, m_busy_a, m_ready_a, m_done_a});
      end
      if (tx_a[0] !== last) begin tq.push_back(t); last = tx_a[0]; end
      if (done_a[0]) dn++;
    end
    n_chk++;
    if (t >= 2000) begin n_fail++; $display("FAIL single_timeout: cycles %0d required <2000", t); end
    n_chk++;
    if (dn != 1) begin n_fail++; $display("FAIL single_done: pulses %0d required 1", dn); end
    n_chk++;
    if (tq.size() != 7) begin
      n_fail++; $display("FAIL single_edges: transitions %0d required 7", tq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_chk++;
        if (tq[i+1] - tq[i] != iv[i]) begin
          n_fail++;
          $display("FAIL single_bit_width[%0d]: clks %0d required %0d", i, tq[i+1] - tq[i], iv[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int t;
    int dn[4], rise[4], hi[4], hexp[4];
    logic [3:0] last;
    hexp = '{64, 64, 128, 128};
    dn = '{0, 0, 0, 0}; rise = '{0, 0, 0, 0}; hi = '{0, 0, 0, 0};
    @(posedge clk);
    #1;
    tx_start = 1'b1; tx_din = 8'h55;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    tx_start = 1'b1; tx_din = 8'h0F;
    @(negedge clk);
    n_chk++;
    if (ready_a !== 4'hF) begin n_fail++; $display("FAIL b2b_ready_pre: got %h required F", ready_a); end
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    @(negedge clk);
    n_chk++;
    if (ready_a !== 4'h0) begin n_fail++; $display("FAIL b2b_ready_low: got %h required 0", ready_a); end
    last = tx_a; t = 0;
    while ((m_busy_a != 4'h0 || m_ready_a != 4'hF) && t < 3000) begin
      @(negedge clk);
      t++;
      n_chk++;
      if ({tx_a, busy_a, ready_a, done_a} !== {m_tx_a, m_busy_a, m_ready_a, m_done_a}) begin
        n_fail++;
        $display("FAIL b2b_cycle t=%0t: got %h required %h", $time,
                 {tx_a, busy_a, ready_a, done_a}, {m_tx_a, m_busy_a, m_ready_a, m_done_a});
      end
      for (int i = 0; i < 4; i++) begin
        if (done_a[i]) dn[i]++;
        if (tx_a[i] && !last[i]) rise[i] = t;
        if (!tx_a[i] && last[i] && dn[i] == 1 && hi[i] == 0) begin
          hi[i] = t - rise[i];
          n_chk++;
          if (ready_a[i] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready_release cfg%0d: got %b required 1", i, ready_a[i]);
          end
        end
      end
      last = tx_a;
    end
    n_chk++;
    if (t >= 3000) begin n_fail++; $display("FAIL b2b_timeout: cycles %0d required <3000", t); end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (dn[i] != 2) begin n_fail++; $display("FAIL b2b_done cfg%0d: pulses %0d required 2", i, dn[i]); end
      n_chk++;
      if (hi[i] != hexp[i]) begin
        n_fail++; $display("FAIL stop_len cfg%0d: high clks %0d required %0d", i, hi[i], hexp[i]);
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] w[2];
    logic [1:0] pexp[2];
    int t;
    w = '{8'hA5, 8'h07};
    pexp = '{2'b10, 2'b01};  // {odd cfg2, even cfg1}
    for (int f = 0; f < 2; f++) begin
      @(posedge clk);
      #1;
      tx_start = 1'b1; tx_din = w[f];
      @(posedge clk);
      #1;
      tx_start = 1'b0;
      t = 0;
      while (!(m_busy_a[1] && k_a[1] == 152) && t < 2000) begin @(negedge clk); t++; end
      n_chk++;
      if (t >= 2000) begin n_fail++; $display("FAIL parity_wait: cycles %0d required <2000", t); end
      n_chk++;
      if (tx_a[2:1] !== pexp[f]) begin
        n_fail++; $display("FAIL parity_bit %h: odd/even got %b required %b", w[f], tx_a[2:1], pexp[f]);
      end
      t = 0;
      while (m_busy_a != 4'h0 && t < 2000) begin @(negedge clk); t++; end
      n_chk++;
      if (busy_a !== 4'h0) begin n_fail++; $display("FAIL parity_idle: busy got %h required 0", busy_a); end
    end
  endtask

  task automatic test_write_full();
    int t, j, t0, dn;
    bit dec_on;
    logic [7:0] by;
    logic [7:0] got[$];
    logic last;
    @(posedge clk);
    #1;
    tx_start = 1'b1; tx_din = 8'h55;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    @(negedge clk);
    last = tx_a[0]; dec_on = 1'b1; t0 = 0; j = 0; t = 0; dn = 0; by = '0;
    repeat (30) @(posedge clk);
    #1;
    tx_start = 1'b1; tx_din = 8'h0F;
    @(posedge clk);
    #1;
    tx_din = 8'hFF;
    @(negedge clk);
    n_chk++;
    if (ready_a !== 4'h0) begin n_fail++; $display("FAIL full_ready: got %h required 0", ready_a); end
    t = 32;
    repeat (2) @(posedge clk);
    #1;
    tx_start = 1'b0;
    while ((m_busy_a != 4'h0 || m_ready_a != 4'hF) && t < 3000) begin
      @(negedge clk);
      t++;
      n_chk++;
      if ({tx_a, busy_a, ready_a, done_a} !== {m_tx_a, m_busy_a, m_ready_a, m_done_a}) begin
        n_fail++;
        $display("FAIL full_cycle t=%0t: got %h required %h", $time,
                 {tx_a, busy_a, ready_a, done_a}, {m_tx_a, m_busy_a, m_ready_a, m_done_a});
      end
      if (done_a[0]) dn++;
      // Line decode of cfg0: mid-bit sample at fall + 96 + 64*j clks.
      if (!dec_on && last && !tx_a[0]) begin
        dec_on = 1'b1; t0 = t; j = 0;
      end else if (dec_on && t == t0 + 96 + 64 * j) begin
        by[j] = tx_a[0]; j++;
        if (j == 8) begin got.push_back(by); dec_on = 1'b0; end
      end
      last = tx_a[0];
    end
    n_chk++;
    if (t >= 3000) begin n_fail++; $display("FAIL full_timeout: cycles %0d required <3000", t); end
    n_chk++;
    if (dn != 2) begin n_fail++; $display("FAIL full_done: pulses %0d required 2", dn); end
    n_chk++;
    if (got.size() != 2) begin
      n_fail++; $display("FAIL full_bytes: count %0d required 2", got.size());
    end else begin
      n_chk++;
      if (got[0] !== 8'h55 || got[1] !== 8'h0F) begin
        n_fail++; $display("FAIL full_bytes: got %h %h required 55 0F", got[0], got[1]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int t;
    bit act_seen;
    @(posedge clk);
    #1;
    tx_start = 1'b1; tx_din = 8'h3C;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    tx_start = 1'b1; tx_din = 8'hC3;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    t = 0;
    while (!(m_busy_a[0] && k_a[0] >= 72) && t < 2000) begin @(negedge clk); t++; end
    n_chk++;
    if (t >= 2000) begin n_fail++; $display("FAIL rst_mid_wait: cycles %0d required <2000", t); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy_a !== 4'hF || ready_a !== 4'h0) begin
      n_fail++; $display("FAIL rst_mid_pre: busy/ready got %h %h required F 0", busy_a, ready_a);
    end
    @(negedge clk);
    n_chk++;
    if ({tx_a, busy_a, ready_a, done_a} !== 16'hF0F0) begin
      n_fail++;
      $display("FAIL rst_mid_after: tx/busy/ready/done got %h required F0F0", {tx_a, busy_a, ready_a, done_a});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    act_seen = 1'b0;
    repeat (800) begin
      @(negedge clk);
      if (tx_a !== 4'hF || busy_a !== 4'h0 || done_a !== 4'h0) act_seen = 1'b1;
    end
    n_chk++;
    if (act_seen) begin n_fail++; $display("FAIL rst_mid_discard: activity got 1 required 0"); end
  endtask

  task automatic test_random();
    int t;
    tick_rand = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      tx_start = ($urandom_range(0, 29) == 0);
      tx_din   = 8'($urandom);
      reset    = ($urandom_range(0, 1499) == 0);
      @(negedge clk);
      n_chk++;
      if ({tx_a, busy_a, ready_a, done_a} !== {m_tx_a, m_busy_a, m_ready_a, m_done_a}) begin
        n_fail++;
        $display("FAIL random_cycle t=%0t: got %h required %h", $time,
                 {tx_a, busy_a, ready_a, done_a}, {m_tx_a, m_busy_a, m_ready_a, m_done_a});
      end
    end
    @(posedge clk);
    #1;
    tx_start = 1'b0; reset = 1'b0;
    t = 0;
    while ((m_busy_a != 4'h0 || m_ready_a != 4'hF) && t < 5000) begin @(negedge clk); t++; end
    n_chk++;
    if ({busy_a, ready_a, tx_a} !== 12'h0FF) begin
      n_fail++; $display("FAIL random_drain: busy/ready/tx got %h required 0FF", {busy_a, ready_a, tx_a});
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; tick_rand = 1'b0;
    reset = 1'b1; tx_start = 1'b0; tx_din = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_parity();
    test_write_full();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
